// File: rtl/Full_Adder.sv
// rtl/Full_Adder.sv - one-bit combinational full adder cell
module Full_Adder (
  input  logic A,
  input  logic B,
  input  logic C_in,
  output logic Sum,
  output logic C_out
);

  assign Sum   = A ^ B ^ C_in;
  assign C_out = (A & B) | (C_in & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder around one Full_Adder cell, LSB first
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             C_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;

  Full_Adder fa (
    .A    (opa[0]),
    .B    (opb[0]),
    .C_in (carry),
    .Sum  (fa_sum),
    .C_out(fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Sum   <= '0;
      C_out <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= A;
            opb   <= B;
            carry <= C_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // result bits enter at the MSB so bit 0 lands at res[0] after WIDTH shifts
          res   <= {fa_sum, res[WIDTH-1:1]};
          carry <= fa_cout;
          opa   <= {1'b0, opa[WIDTH-1:1]};
          opb   <= {1'b0, opb[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            Sum   <= {fa_sum, res[WIDTH-1:1]};
            C_out <= fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH=8 and WIDTH=4
module tb_serial_adder;

  typedef struct {
    int v;
    int due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic       rst8 = 1'b1, start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       rst4 = 1'b1, start4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .A(a8), .B(b8), .C_in(cin8),
    .busy(busy8), .done(done8), .Sum(sum8), .C_out(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .A(a4), .B(b4), .C_in(cin4),
    .busy(busy4), .done(done4), .Sum(sum4), .C_out(cout4)
  );

  exp_t q8[$];
  exp_t q4[$];
  int   blen8 = 0;
  int   blen4 = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors: result value, start-to-done latency and busy length
  always @(negedge clk) begin
    exp_t e;
    if (rst8) begin
      blen8 = 0;
    end else begin
      if (busy8) blen8++;
      if (done8) begin
        chk("busy_done_overlap8", int'(busy8), 0);
        if (q8.size() == 0) begin
          chk("unexpected_done8", 1, 0);
        end else begin
          e = q8.pop_front();
          chk("result8", int'({cout8, sum8}), e.v);
          chk("latency8", cyc, e.due);
          chk("busy_len8", blen8, 8);
        end
        blen8 = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst4) begin
      blen4 = 0;
    end else begin
      if (busy4) blen4++;
      if (done4) begin
        if (q4.size() == 0) begin
          chk("unexpected_done4", 1, 0);
        end else begin
          e = q4.pop_front();
          chk("result4", int'({cout4, sum4}), e.v);
          chk("latency4", cyc, e.due);
          chk("busy_len4", blen4, 4);
        end
        blen4 = 0;
      end
    end
  end

  // Called between edges; the next rising edge accepts the request
  task automatic op8(input int a, input int b, input int c);
    exp_t e;
    a8 = a[7:0]; b8 = b[7:0]; cin8 = c[0];
    start8 = 1'b1;
    e.v   = (a & 8'hFF) + (b & 8'hFF) + (c & 1);
    e.due = cyc + 1 + 8;
    q8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
  endtask

  task automatic op4(input int a, input int b, input int c);
    exp_t e;
    a4 = a[3:0]; b4 = b[3:0]; cin4 = c[0];
    start4 = 1'b1;
    e.v   = (a & 4'hF) + (b & 4'hF) + (c & 1);
    e.due = cyc + 1 + 4;
    q4.push_back(e);
    @(posedge clk); #1;
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
  endtask

  task automatic wait_done8(input string nm);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done8) seen = 1;
    end
    if (!seen) chk({"timeout8_", nm}, 0, 1);
  endtask

  task automatic wait_done4();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done4) seen = 1;
    end
    if (!seen) chk("timeout4", 0, 1);
  endtask

  task automatic run8();
    int t1;
    op8(8'h00, 8'h00, 0); wait_done8("zero");
    repeat (2) @(negedge clk);
    op8(8'hFF, 8'h01, 0); wait_done8("ff01");
    op8(8'hA5, 8'h5A, 1); wait_done8("a55a");
    op8(8'h3C, 8'h42, 0); wait_done8("3c42");
    repeat (3) @(negedge clk);

    // A request during RUN must be dropped
    op8(8'h10, 8'h20, 0);
    @(posedge clk); #1;
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8("ignore");
    repeat (15) @(negedge clk);

    // Back-to-back: new request accepted in the DONE cycle
    op8(8'h12, 8'h34, 0); wait_done8("b2b_first");
    t1 = cyc;
    op8(8'h80, 8'h80, 0); wait_done8("b2b_second");
    chk("b2b_gap", cyc - t1, 9);
    repeat (2) @(negedge clk);

    // Reset mid-RUN clears the previous result and produces no done
    op8(8'h3C, 8'h42, 0); wait_done8("pre_reset");
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h66; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst8 = 1'b1;
    #1;
    chk("rst_busy8", int'(busy8), 0);
    chk("rst_done8", int'(done8), 0);
    chk("rst_sum8", int'(sum8), 0);
    chk("rst_cout8", int'(cout8), 0);
    @(posedge clk); #1;
    rst8 = 1'b0;
    repeat (15) @(negedge clk);
    op8(8'h01, 8'h01, 1); wait_done8("post_reset");

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
      wait_done8("random");
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic run4();
    for (int n = 0; n < 512; n++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      op4(n & 15, (n >> 4) & 15, (n >> 8) & 1);
      wait_done4();
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst8 = 1'b0;
    rst4 = 1'b0;
    @(negedge clk);
    chk("reset_busy8", int'(busy8), 0);
    chk("reset_done8", int'(done8), 0);
    chk("reset_sum8", int'(sum8), 0);
    chk("reset_cout8", int'(cout8), 0);
    chk("reset_busy4", int'(busy4), 0);
    chk("reset_result4", int'({cout4, sum4}), 0);
    fork
      run8();
      run4();
    join
    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
